bus_responder: RTL and testbench

// Memory-mapped bus target answering the CPU's bus-initiator port (strobe/we/addr/data, data_ready).

---
 rtl/bus_responder_if.sv | 27 ++
 rtl/bus_responder.sv | 140 ++++++++++++++
 tb/tb_bus_responder.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_responder_if.sv
// Bus-initiator request/response signals plus the FIFO drain port.
// The initiator side drives requests and the target answers them.
interface bus_responder_if;
  logic        i_bus_clk;
  logic        i_bus_we;
  logic [31:0] i_bus_addr;
  logic [31:0] i_bus_data;
  logic [31:0] o_bus_data;
  logic        o_bus_data_ready;
  logic        i_drain_pop;
  logic [7:0]  o_drain_data;
  logic        o_drain_valid;

  modport master (
    output i_bus_clk, i_bus_we, i_bus_addr, i_bus_data,
    output i_drain_pop,
    input  o_bus_data, o_bus_data_ready,
    input  o_drain_data, o_drain_valid
  );

  modport slave (
    input  i_bus_clk, i_bus_we, i_bus_addr, i_bus_data,
    input  i_drain_pop,
    output o_bus_data, o_bus_data_ready,
    output o_drain_data, o_drain_valid
  );
endinterface

// File: rtl/bus_responder.sv
// Bus target with wait states, two scratch registers, a push FIFO
// with a side drain port, and a status register with sticky flags.
module bus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input logic            i_clk,
  input logic            i_rst,
  bus_responder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  off;
    logic [31:0] wdata;
  } req_t;

  state_t        state_q, state_d;
  req_t          req_q;
  logic [3:0]    wait_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   scr0_q, scr1_q;
  logic          ovf_q, unf_q;
  logic [31:0]   data_q;
  logic          ready_q;

  logic        hit, start, in_ack;
  logic        empty, full;
  logic        bus_push, bus_pop, st_wr;
  logic        drain_valid, drain_pop;
  logic        push_ok, pop_any;
  logic [7:0]  head;
  logic [31:0] status, rdata;

  assign hit    = bus.i_bus_addr[31:4] == BASE_ADDR[31:4];
  assign start  = bus.i_bus_clk && hit;
  assign in_ack = state_q == ACK;

  assign empty = cnt_q == '0;
  assign full  = cnt_q == CW'(FIFO_DEPTH);
  assign head  = mem[rd_q];

  assign bus_push = in_ack && req_q.we && req_q.off == 2'd2;
  assign bus_pop  = in_ack && !req_q.we && req_q.off == 2'd2;
  assign st_wr    = in_ack && req_q.we && req_q.off == 2'd3;

  // Block the drain while a bus pop retires so both never hit the head.
  assign drain_valid = !empty && !bus_pop;
  assign drain_pop   = bus.i_drain_pop && drain_valid;
  assign push_ok     = bus_push && (!full || drain_pop);
  assign pop_any     = drain_pop || (bus_pop && !empty);

  assign status = {19'b0, unf_q, ovf_q, full, empty, 9'(cnt_q)};

  always_comb begin
    rdata = '0;
    unique case (req_q.off)
      2'd0: rdata = scr0_q;
      2'd1: rdata = scr1_q;
      2'd2: rdata = empty ? 32'd0 : {24'b0, head};
      2'd3: rdata = status;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = WAIT;
      WAIT: if (wait_q == 4'd0) state_d = ACK;
      ACK:  state_d = HOLD;
      HOLD: if (!bus.i_bus_clk) state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_q   <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= in_ack;
      if (state_q == IDLE && start) begin
        req_q  <= '{we: bus.i_bus_we, off: bus.i_bus_addr[3:2],
                   wdata: bus.i_bus_data};
        wait_q <= 4'(WAIT_STATES);
      end else if (state_q == WAIT && wait_q != 4'd0) begin
        wait_q <= wait_q - 4'd1;
      end
      if (in_ack)
        data_q <= req_q.we ? 32'd0 : rdata;
      else if (state_q == HOLD && !bus.i_bus_clk)
        data_q <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scr0_q <= '0;
      scr1_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (in_ack && req_q.we && req_q.off == 2'd0) scr0_q <= req_q.wdata;
      if (in_ack && req_q.we && req_q.off == 2'd1) scr1_q <= req_q.wdata;
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_any) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_any);
      // A fresh event outranks a same-cycle clear.
      if (bus_push && full && !drain_pop) ovf_q <= 1'b1;
      else if (st_wr)                     ovf_q <= 1'b0;
      if (bus_pop && empty) unf_q <= 1'b1;
      else if (st_wr)       unf_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_q] <= req_q.wdata[7:0];
  end

  assign bus.o_bus_data       = data_q;
  assign bus.o_bus_data_ready = ready_q;
  assign bus.o_drain_data     = empty ? 8'd0 : head;
  assign bus.o_drain_valid    = drain_valid;
endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: registers, FIFO edges,
// wait-state latency, address miss and mid-transaction reset.
module tb_bus_responder;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bus_responder_if bif ();

  bus_responder #(
    .BASE_ADDR  (BASE),
    .WAIT_STATES(2),
    .FIFO_DEPTH (16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns latency in cycles (-1 on timeout).
  task automatic bus_xfer(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
    lat = -1;
    rd  = '0;
    bif.i_bus_we   = we;
    bif.i_bus_addr = addr;
    bif.i_bus_data = wd;
    bif.i_bus_clk  = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bif.o_bus_data_ready) begin
        lat = k;
        rd  = bif.o_bus_data;
        break;
      end
    end
    bif.i_bus_clk = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bif.o_bus_data_ready !== 1'b0 || bif.o_bus_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus: ready=%b data=%h want 0/0",
               bif.o_bus_data_ready, bif.o_bus_data);
    end
    checks++;
    if (bif.o_drain_valid !== 1'b0 || bif.o_drain_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_drain: valid=%b data=%h want 0/00",
               bif.o_drain_valid, bif.o_drain_data);
    end
    rst = 1'b0;
    @(negedge clk);
    bus_xfer(1'b0, BASE + 32'hC, 32'd0, rd, lat);
    checks++;
    if (rd !== 32'h0000_0200 || lat !== 4) begin
      errors++;
      $display("FAIL reset_status: got %h lat %0d want 00000200 lat 4",
               rd, lat);
    end
  endtask

  task automatic test_scratch();
    logic [31:0] rd;
    int lat;
    bus_xfer(1'b1, BASE + 32'h0, 32'hDEAD_BEEF, rd, lat);
    checks++;
    if (lat !== 4 || rd !== 32'd0) begin
      errors++;
      $display("FAIL scr_write: lat %0d data %h want 4 / 0", lat, rd);
    end
    checks++;
    if (bif.o_bus_data_ready !== 1'b0 || bif.o_bus_data !== 32'd0) begin
      errors++;
      $display("FAIL ready_pulse: ready=%b data=%h want 0/0",
               bif.o_bus_data_ready, bif.o_bus_data);
    end
    bus_xfer(1'b0, BASE + 32'h0, 32'd0, rd, lat);
    checks++;
    if (lat !== 4 || rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL scr0_read: lat %0d data %h want 4 / deadbeef",
               lat, rd);
    end
    bus_xfer(1'b0, BASE + 32'h4, 32'd0, rd, lat);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL scr1_read: got %h want 0", rd);
    end
    bus_xfer(1'b1, BASE + 32'h4, 32'h1234_5678, rd, lat);
    bus_xfer(1'b0, BASE + 32'h4, 32'd0, rd, lat);
    checks++;
    if (rd !== 32'h1234_5678) begin
      errors++;
      $display("FAIL scr1_rw: got %h want 12345678", rd);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    int lat;
    int bad;
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      bus_xfer(1'b1, BASE + 32'h8, 32'hFFFF_FF00 | i, rd, lat);
      if (lat != 4) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL push_lat: %0d pushes timed wrong want 0", bad);
    end
    bus_xfer(1'b0, BASE + 32'hC, 32'd0, rd, lat);
    checks++;
    if (rd !== 32'h0000_0C10) begin
      errors++;
      $display("FAIL ovf_status: got %h want 00000c10", rd);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bif.o_drain_valid !== 1'b1 || bif.o_drain_data !== 8'(i)) begin
        errors++;
        $display("FAIL drain_%0d: valid=%b data=%h want 1/%h",
                 i, bif.o_drain_valid, bif.o_drain_data, 8'(i));
      end
      bif.i_drain_pop = 1'b1;
      @(negedge clk);
      bif.i_drain_pop = 1'b0;
    end
    checks++;
    if (bif.o_drain_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: valid=%b want 0", bif.o_drain_valid);
    end
    bus_xfer(1'b0, BASE + 32'hC, 32'd0, rd, lat);
    checks++;
    if (rd !== 32'h0000_0A00) begin
      errors++;
      $display("FAIL empty_status: got %h want 00000a00", rd);
    end
    bus_xfer(1'b1, BASE + 32'hC, 32'd0, rd, lat);
  endtask

  task automatic test_full_push_pop();
    logic [31:0] rd;
    int lat;
    for (int i = 0; i < 16; i++)
      bus_xfer(1'b1, BASE + 32'h8, 32'h10 + i, rd, lat);
    bif.i_bus_we   = 1'b1;
    bif.i_bus_addr = BASE + 32'h8;
    bif.i_bus_data = 32'h0000_00AA;
    bif.i_bus_clk  = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bif.o_drain_valid !== 1'b1 || bif.o_drain_data !== 8'h10) begin
      errors++;
      $display("FAIL full_head: valid=%b data=%h want 1/10",
               bif.o_drain_valid, bif.o_drain_data);
    end
    bif.i_drain_pop = 1'b1;
    @(negedge clk);
    bif.i_drain_pop = 1'b0;
    checks++;
    if (bif.o_bus_data_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_pop_ready: got %b want 1", bif.o_bus_data_ready);
    end
    bif.i_bus_clk = 1'b0;
    @(negedge clk);
    bus_xfer(1'b0, BASE + 32'hC, 32'd0, rd, lat);
    checks++;
    if (rd !== 32'h0000_0410) begin
      errors++;
      $display("FAIL push_pop_status: got %h want 00000410", rd);
    end
    for (int i = 1; i < 16; i++) begin
      bif.i_drain_pop = 1'b1;
      @(negedge clk);
    end
    bif.i_drain_pop = 1'b0;
    checks++;
    if (bif.o_drain_valid !== 1'b1 || bif.o_drain_data !== 8'hAA) begin
      errors++;
      $display("FAIL last_byte: valid=%b data=%h want 1/aa",
               bif.o_drain_valid, bif.o_drain_data);
    end
    bif.i_drain_pop = 1'b1;
    @(negedge clk);
    bif.i_drain_pop = 1'b0;
  endtask

  task automatic test_underflow();
    logic [31:0] rd;
    int lat;
    bus_xfer(1'b1, BASE + 32'h8, 32'h0000_005A, rd, lat);
    bus_xfer(1'b0, BASE + 32'h8, 32'd0, rd, lat);
    checks++;
    if (rd !== 32'h0000_005A) begin
      errors++;
      $display("FAIL bus_pop: got %h want 0000005a", rd);
    end
    bus_xfer(1'b0, BASE + 32'h8, 32'd0, rd, lat);
    checks++;
    if (rd !== 32'd0 || lat !== 4) begin
      errors++;
      $display("FAIL unf_read: got %h lat %0d want 0 lat 4", rd, lat);
    end
    bus_xfer(1'b0, BASE + 32'hC, 32'd0, rd, lat);
    checks++;
    if (rd !== 32'h0000_1200) begin
      errors++;
      $display("FAIL unf_status: got %h want 00001200", rd);
    end
    bus_xfer(1'b1, BASE + 32'hC, 32'hFFFF_FFFF, rd, lat);
    bus_xfer(1'b0, BASE + 32'hC, 32'd0, rd, lat);
    checks++;
    if (rd !== 32'h0000_0200) begin
      errors++;
      $display("FAIL flag_clear: got %h want 00000200", rd);
    end
  endtask

  task automatic test_miss_and_reset();
    logic [31:0] rd;
    int lat;
    int seen;
    seen = 0;
    bif.i_bus_we   = 1'b0;
    bif.i_bus_addr = BASE + 32'h20;
    bif.i_bus_clk  = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bif.o_bus_data_ready) seen++;
    end
    bif.i_bus_clk = 1'b0;
    @(negedge clk);
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL miss: %0d ready pulses want 0", seen);
    end
    seen = 0;
    bif.i_bus_we   = 1'b1;
    bif.i_bus_addr = BASE + 32'h8;
    bif.i_bus_data = 32'h0000_0077;
    bif.i_bus_clk  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bif.i_bus_clk = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bif.o_bus_data_ready) seen++;
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bif.o_bus_data_ready) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_abort: %0d ready pulses want 0", seen);
    end
    checks++;
    if (bif.o_drain_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_drain: valid=%b want 0", bif.o_drain_valid);
    end
    bus_xfer(1'b0, BASE + 32'hC, 32'd0, rd, lat);
    checks++;
    if (rd !== 32'h0000_0200) begin
      errors++;
      $display("FAIL rst_status: got %h want 00000200", rd);
    end
  endtask

  initial begin
    bif.i_bus_clk   = 1'b0;
    bif.i_bus_we    = 1'b0;
    bif.i_bus_addr  = '0;
    bif.i_bus_data  = '0;
    bif.i_drain_pop = 1'b0;
    test_reset();
    test_scratch();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_miss_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
